// File: rtl/dft_frame_buffer_if.sv
// Sample-in / frame-out handshake bundle for dft_frame_buffer.
// master = sample producer plus frame consumer; slave = the frame buffer.
interface dft_frame_buffer_if #(
   parameter int N = 16,
   parameter int W = 4
);
   localparam int LW = $clog2(N) + 1;

   logic            s_valid;
   logic            s_ready;
   logic [W-1:0]    s_data;
   logic            s_last;
   logic            frame_valid;
   logic            frame_ready;
   logic [N*W-1:0]  frame_data;
   logic [LW-1:0]   frame_len;

   modport master (
      output s_valid, s_data, s_last, frame_ready,
      input  s_ready, frame_valid, frame_data, frame_len
   );

   modport slave (
      input  s_valid, s_data, s_last, frame_ready,
      output s_ready, frame_valid, frame_data, frame_len
   );
endinterface

// File: rtl/dft_frame_buffer.sv
// Ping-pong sample framer feeding the 16-point DFT: packs W-bit samples into N-slot frames.
// Optional early frame close on s_last with zero-masked tail: define DFT_FB_ZERO_PAD_EN.
module dft_frame_buffer #(
   parameter int N = 16,
   parameter int W = 4
) (
   input logic               clk,
   input logic               rst_n,
   dft_frame_buffer_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int LW = IW + 1;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_st_e;

   bank_st_e        st_q   [2];
   bank_st_e        st_d   [2];
   logic [N*W-1:0]  mem_q  [2];
   logic [N*W-1:0]  mem_d  [2];
   logic [LW-1:0]   len_q  [2];
   logic [LW-1:0]   len_d  [2];
   logic            wr_bank_q, wr_bank_d;
   logic            rd_bank_q, rd_bank_d;
   logic [IW-1:0]   wr_idx_q,  wr_idx_d;
   logic            en_q;
   logic            wr_fire, rd_fire, last_w;
   logic [N*W-1:0]  frame_data_w;

   assign bus.s_ready     = en_q && (st_q[wr_bank_q] != FULL);
   assign bus.frame_valid = (st_q[rd_bank_q] == FULL);
   assign bus.frame_len   = len_q[rd_bank_q];
   assign bus.frame_data  = frame_data_w;

   assign wr_fire = bus.s_valid && bus.s_ready;
   assign rd_fire = bus.frame_valid && bus.frame_ready;

`ifdef DFT_FB_ZERO_PAD_EN
   assign last_w = bus.s_last;

   // Storage is never cleared; slots past frame_len are hidden on the way out.
   always_comb begin
      frame_data_w = mem_q[rd_bank_q];
      for (int unsigned i = 0; i < N; i++) begin
         if (LW'(i) >= len_q[rd_bank_q]) frame_data_w[i*W +: W] = '0;
      end
   end
`else
   logic unused_s_last;
   assign unused_s_last = bus.s_last;
   assign last_w        = 1'b0;
   assign frame_data_w  = mem_q[rd_bank_q];
`endif

   // Read and write can never target the same bank in one cycle: a write needs
   // a non-FULL bank, a read needs a FULL one, so both updates apply independently.
   always_comb begin
      st_d      = st_q;
      mem_d     = mem_q;
      len_d     = len_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;

      if (rd_fire) begin
         st_d[rd_bank_q] = EMPTY;
         rd_bank_d       = !rd_bank_q;
      end

      if (wr_fire) begin
         mem_d[wr_bank_q][wr_idx_q*W +: W] = bus.s_data;
         if ((wr_idx_q == IW'(N-1)) || last_w) begin
            st_d[wr_bank_q]  = FULL;
            len_d[wr_bank_q] = LW'(wr_idx_q) + LW'(1);
            wr_idx_d         = '0;
            wr_bank_d        = !wr_bank_q;
         end else begin
            st_d[wr_bank_q]  = FILLING;
            wr_idx_d         = wr_idx_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= '{default: EMPTY};
         mem_q     <= '{default: '0};
         len_q     <= '{default: '0};
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         en_q      <= 1'b0;
      end else begin
         st_q      <= st_d;
         mem_q     <= mem_d;
         len_q     <= len_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_idx_q  <= wr_idx_d;
         en_q      <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dft_frame_buffer.sv
// Scoreboard bench for dft_frame_buffer: directed scenarios plus randomized traffic.
// Reference frames are built from accepted samples; honours DFT_FB_ZERO_PAD_EN.
module tb_dft_frame_buffer;
   localparam int N = 16;
   localparam int W = 4;
`ifdef DFT_FB_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   typedef struct {
      logic [N*W-1:0] data;
      int             len;
   } frame_t;

   logic   clk;
   logic   rst_n;
   int     n_checks = 0;
   int     n_fail   = 0;
   frame_t exp_q[$];
   logic [W-1:0] cur[$];

   dft_frame_buffer_if #(.N(N), .W(W)) bus ();

   dft_frame_buffer #(.N(N), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: collect accepted samples, emit a frame when N arrive
   // (or on s_last when early close is enabled).
   always @(negedge clk) begin
      if (!rst_n) begin
         cur.delete();
         exp_q.delete();
      end else if (bus.s_valid && bus.s_ready) begin
         cur.push_back(bus.s_data);
         if (cur.size() == N || (PAD && bus.s_last)) begin
            frame_t f;
            f.data = '0;
            for (int i = 0; i < cur.size(); i++) f.data[i*W +: W] = cur[i];
            f.len = cur.size();
            exp_q.push_back(f);
            cur.delete();
         end
      end
   end

   // Monitor: compare each handshaken frame and check stability while stalled.
   logic           stall_q = 1'b0;
   logic [N*W-1:0] prev_data;
   logic [4:0]     prev_len;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("hold_valid", 64'(bus.frame_valid), 64'd1);
            if (bus.frame_valid) begin
               chk("hold_data", bus.frame_data, prev_data);
               chk("hold_len", 64'(bus.frame_len), 64'(prev_len));
            end
         end
         if (bus.frame_valid && bus.frame_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 64'(bus.frame_valid), 64'd0);
            end else begin
               frame_t f;
               f = exp_q.pop_front();
               chk("frame_data", bus.frame_data, f.data);
               chk("frame_len", 64'(bus.frame_len), 64'(f.len));
            end
         end
         stall_q   = bus.frame_valid && !bus.frame_ready;
         prev_data = bus.frame_data;
         prev_len  = bus.frame_len;
      end
   end

   task automatic send(input logic [W-1:0] d, input logic last);
      bit done;
      done = 1'b0;
      bus.s_data  = d;
      bus.s_last  = last;
      bus.s_valid = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (bus.s_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) begin
         chk("send_timeout", 64'd0, 64'd1);
         bus.s_valid = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N*W-1:0] bexp;
      int acc;

      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.s_last = 1'b0;
      bus.frame_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset state and ready enable
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
      chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
      chk("rst_frame_data", bus.frame_data, 64'd0);
      chk("rst_frame_len", 64'(bus.frame_len), 64'd0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_before_edge", 64'(bus.s_ready), 64'd0);
      step();
      @(negedge clk);
      chk("ready_after_edge", 64'(bus.s_ready), 64'd1);
      step();

      // Full frame, back-to-back, consumer always ready
      bus.frame_ready = 1'b1;
      for (int i = 0; i < N; i++) send(W'(i), 1'b0);
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("full_valid_latency", 64'(bus.frame_valid), 64'd1);
      chk("full_data", bus.frame_data, 64'hFEDC_BA98_7654_3210);
      chk("full_len", 64'(bus.frame_len), 64'd16);
      step();
      @(negedge clk);
      chk("full_valid_one_cycle", 64'(bus.frame_valid), 64'd0);
      step();

      // Backpressure: 40 offers with consumer stalled
      bus.frame_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         bus.s_valid = 1'b1;
         bus.s_data = W'($urandom);
         @(negedge clk);
         if (bus.s_ready) acc++;
         step();
      end
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("bp_accepted", 64'(acc), 64'd32);
      chk("bp_ready_low", 64'(bus.s_ready), 64'd0);
      chk("bp_valid", 64'(bus.frame_valid), 64'd1);
      step();
      bus.frame_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_at_release", 64'(bus.s_ready), 64'd0);
      step();
      @(negedge clk);
      chk("bp_ready_after_release", 64'(bus.s_ready), 64'd1);
      chk("bp_second_valid", 64'(bus.frame_valid), 64'd1);
      step();
      @(negedge clk);
      chk("bp_drained", 64'(bus.frame_valid), 64'd0);
      step();

      // Same-cycle release of A and completion of B
      bus.frame_ready = 1'b0;
      bexp = '0;
      for (int i = 0; i < 2*N - 1; i++) begin
         logic [W-1:0] d;
         d = W'($urandom);
         if (i >= N) bexp[(i-N)*W +: W] = d;
         send(d, 1'b0);
      end
      bus.s_data = W'($urandom);
      bexp[(N-1)*W +: W] = bus.s_data;
      bus.frame_ready = 1'b1;
      @(negedge clk);
      chk("same_cycle_pre", 64'({bus.s_ready, bus.frame_valid}), 64'd3);
      step();
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("same_cycle_no_gap", 64'(bus.frame_valid), 64'd1);
      chk("same_cycle_b_data", bus.frame_data, bexp);
      step();
      repeat (2) step();

      // Short frame with s_last on the 8th sample
      for (int i = 1; i <= 8; i++) send(W'(i), (i == 8));
      bus.s_valid = 1'b0;
      bus.s_last = 1'b0;
      @(negedge clk);
`ifdef DFT_FB_ZERO_PAD_EN
      chk("pad_valid", 64'(bus.frame_valid), 64'd1);
      chk("pad_data", bus.frame_data, 64'h0000_0000_8765_4321);
      chk("pad_len", 64'(bus.frame_len), 64'd8);
      step();
`else
      chk("nopad_no_frame", 64'(bus.frame_valid), 64'd0);
      step();
      for (int i = 9; i <= 16; i++) send(W'(i), 1'b0);
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("nopad_valid", 64'(bus.frame_valid), 64'd1);
      chk("nopad_data", bus.frame_data, 64'h0FED_CBA9_8765_4321);
      chk("nopad_len", 64'(bus.frame_len), 64'd16);
      step();
`endif
      repeat (2) step();

      // Reset mid-fill
      for (int i = 0; i < 5; i++) send(W'($urandom), 1'b0);
      bus.s_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 64'(bus.s_ready), 64'd0);
      chk("midrst_valid", 64'(bus.frame_valid), 64'd0);
      repeat (2) step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_valid", 64'(bus.frame_valid), 64'd0);
      step();
      for (int i = 0; i < N; i++) send(W'(i), 1'b0);
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("postrst_valid_frame", 64'(bus.frame_valid), 64'd1);
      chk("postrst_data", bus.frame_data, 64'hFEDC_BA98_7654_3210);
      step();
      repeat (2) step();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         bus.s_valid = ($urandom_range(0, 3) != 0);
         bus.s_data = W'($urandom);
         bus.s_last = ($urandom_range(0, 7) == 0);
         bus.frame_ready = $urandom_range(0, 1) == 1;
         step();
      end
      bus.s_valid = 1'b0;
      bus.s_last = 1'b0;
      bus.frame_ready = 1'b1;
      repeat (40) step();
      @(negedge clk);
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_no_valid", 64'(bus.frame_valid), 64'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dft_frame_buffer.md
# dft_frame_buffer

Upstream sample framer for the 16-point DFT. It accepts a stream of 4-bit samples over a valid/ready handshake and packs them into 16-sample frames. Frames use ping-pong double buffering, so one frame is held stable for the DFT while the next one fills. Each completed frame is presented as a flat 64-bit bus that maps directly onto the DFT's `x[15:0]` input: sample 0 is in bits [3:0], sample 15 in bits [63:60].

## Interface
- `N`, 16: samples per frame; must be a power of two ≥ 2.
- `W`, 4: sample width in bits.
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `s_valid` input, 1: upstream sample valid.
- `s_ready` output, 1: block can accept a sample this cycle.
- `s_data` input, W: sample; taken on a cycle with `s_valid && s_ready`.
- `s_last` input, 1: marks the final sample of a short frame; used only with `DFT_FB_ZERO_PAD_EN`.
- `frame_valid` output, 1: a full frame is presented.
- `frame_ready` input, 1: DFT consumes the frame; handshake completes on `frame_valid && frame_ready`.
- `frame_data` output, N*W: packed frame; slot i is in bits [i*W +: W].
- `frame_len` output, $clog2(N)+1: number of real samples in the frame (1..N).

## Operation
- There are two banks, A and B. Each holds N×W data, a length, and a state: EMPTY, FILLING or FULL.
- There are two 1-bit pointers: `wr_bank` and `rd_bank`.
- Accepting a sample:
  - An accepted sample is written to slot `wr_idx` of `wr_bank`. The bank enters FILLING and `wr_idx` increments.
  - When `wr_idx` reaches N−1 and a sample is accepted, the bank goes to FULL and `wr_idx` wraps to 0.
  - At that point `wr_bank` toggles and the bank length is set to N.
- `s_ready` = !(state[wr_bank] == FULL). When both banks are FULL, `s_ready` is 0.
- `frame_valid` = (state[rd_bank] == FULL).
- `frame_data` and `frame_len` reflect `rd_bank`. They are stable while `frame_valid` is high and not yet handshaken.
- On a frame handshake:
  - `rd_bank` becomes EMPTY and `rd_bank` toggles.
  - Bank data is not cleared.
  - `frame_data` when `frame_valid` is 0 is don't-care.
- Same-cycle events:
  - A frame handshake on bank X and a fill-completing write on bank Y (X≠Y) in the same cycle are both honoured.
  - Result: X is EMPTY, Y is FULL, and `frame_valid` stays 1 with Y's data in the next cycle.
- `frame_ready` may be asserted before `frame_valid`. The block must not wait on it.

## Timing
- Reset values:
  - `s_ready`=0, `frame_valid`=0, `frame_data`=0, `frame_len`=0.
  - Both banks EMPTY, both pointers 0, `wr_idx`=0.
- `s_ready` comes from a registered enable. It rises on the first `clk` edge after `rst_n` deasserts.
- Latency: the edge that accepts sample N−1 makes `frame_valid` read 1 in the following cycle (1 cycle).
- Throughput: one sample per cycle sustained, provided the consumer handshakes each frame within N cycles.
- Reset asserted mid-fill or mid-present discards all data immediately. No partial frame is emitted afterwards.
- `s_valid`, `s_data` and `s_last` are ignored while `s_ready`=0.

## Configuration
- `DFT_FB_ZERO_PAD_EN` defined:
  - An accepted sample with `s_last`=1 closes the current bank early: FULL, `frame_len` = `wr_idx`+1, `wr_idx` reset to 0.
  - Slots `wr_idx`+1..N−1 read as 0 in `frame_data`. They are masked by `frame_len` on output, not cleared in storage.
  - `s_last` on slot N−1 behaves as a normal fill.
- `DFT_FB_ZERO_PAD_EN` undefined:
  - `s_last` is ignored.
  - Every frame has exactly N samples and `frame_len` = N.
  - Unread slots of an old frame are never exposed.

## Test plan
- Reset and ready enable:
  - Hold `rst_n`=0 for 3 cycles → `s_ready`=0, `frame_valid`=0, `frame_data`=0.
  - Release → `s_ready`=1 after the first edge.
- Full frame:
  - Stream samples 0x0..0xF back-to-back with `frame_ready`=1 → `frame_valid` for one cycle, `frame_data`=64'hFEDC_BA98_7654_3210, `frame_len`=16.
- Backpressure:
  - Hold `frame_ready`=0 and offer 40 samples continuously → exactly 32 accepted, then `s_ready`=0.
  - The first frame stays stable.
  - Raise `frame_ready` → frames are released in order and `s_ready` returns to 1 one cycle after the first handshake.
- Same-cycle release and fill:
  - Bank A is FULL; the 16th sample of bank B is accepted in the same cycle as A's handshake → next cycle shows `frame_valid`=1 with B's data and no gap.
- Zero pad (`DFT_FB_ZERO_PAD_EN`):
  - Send 1,2,…,8 with `s_last` on sample 8 → `frame_data`=64'h0000_0000_8765_4321, `frame_len`=8.
  - Repeat without the macro → no frame until 16 samples have been accepted.
- Reset mid-fill:
  - After 5 accepted samples, pulse `rst_n` low → `frame_valid` stays 0.
  - Next 16 samples form a clean frame starting at slot 0.
